// File: rtl/mem_noc_dec_1to2_pkg.sv
// ---------------------------------------------------------------------------
// mem_noc_dec_1to2_pkg
//   Shared types and constants for the memory-NoC 1-to-2 address decoder.
//   Contents:
//     MEM_ADDR_W / MEM_DATA_W / MEM_BE_W  : memory bus widths
//     NOC_TID_S0 / NOC_TID_S1             : target ids driven to the arbiters
//     mem_req_t / mem_resp_t              : request / response beat payloads
//     dec_state_e                         : decoder transaction state
//     noc_addr_hit()                      : masked base compare for region decode
// ---------------------------------------------------------------------------
package mem_noc_dec_1to2_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_BE_W   = MEM_DATA_W / 8;

    localparam logic NOC_TID_S0 = 1'b0;
    localparam logic NOC_TID_S1 = 1'b1;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] req_addr;
        logic                  req_we;
        logic [MEM_BE_W-1:0]   req_be;
        logic [MEM_DATA_W-1:0] req_wdata;
    } mem_req_t;

    typedef struct packed {
        logic [MEM_DATA_W-1:0] resp_rdata;
        logic                  resp_err;
        logic                  resp_last;
    } mem_resp_t;

    typedef enum logic {
        DEC_REQ  = 1'b0,
        DEC_RESP = 1'b1
    } dec_state_e;

    // Region hit: the masked address equals the region base.
    function automatic logic noc_addr_hit(
        input logic [MEM_ADDR_W-1:0] addr,
        input logic [MEM_ADDR_W-1:0] base,
        input logic [MEM_ADDR_W-1:0] mask
    );
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/mem_noc_dec_1to2_req_slice.sv
// ---------------------------------------------------------------------------
// mem_noc_req_slice
//   One-entry valid/ready register slice carrying a mem_req_t plus its decoded
//   target id. Full throughput: a new entry may be pushed in the same cycle
//   the held one is popped. Only built when MEM_NOC_DEC_REQ_SLICE_EN is
//   defined; the default build has no request slice.
//   Ports:
//     clk, rstn             : clock, asynchronous active-low reset
//     in_valid/in_ready     : upstream handshake
//     in_req, in_tid        : upstream payload and decoded target id
//     out_valid/out_ready   : downstream handshake
//     out_req, out_tid      : registered payload and target id
// ---------------------------------------------------------------------------
`ifdef MEM_NOC_DEC_REQ_SLICE_EN
module mem_noc_req_slice
    import mem_noc_dec_1to2_pkg::*;
(
    input  logic     clk,
    input  logic     rstn,
    input  logic     in_valid,
    output logic     in_ready,
    input  mem_req_t in_req,
    input  logic     in_tid,
    output logic     out_valid,
    input  logic     out_ready,
    output mem_req_t out_req,
    output logic     out_tid
);

    logic     full_p0;
    mem_req_t req_p0;
    logic     tid_p0;
    logic     push;
    logic     pop;

    assign pop      = full_p0 & out_ready;
    assign in_ready = ~full_p0 | pop;
    assign push     = in_valid & in_ready;

    // Stage p0: occupancy flag is reset, payload is not (only read while full).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full_p0 <= 1'b0;
        end else if (push) begin
            full_p0 <= 1'b1;
        end else if (pop) begin
            full_p0 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            req_p0 <= in_req;
            tid_p0 <= in_tid;
        end
    end

    assign out_valid = full_p0;
    assign out_req   = req_p0;
    assign out_tid   = tid_p0;

endmodule
`endif

// File: rtl/mem_noc_dec_1to2.sv
// ---------------------------------------------------------------------------
// mem_noc_dec_1to2
//   1-master to 2-slave address decoder/router for the memory NoC. Requests
//   hitting the slave-1 region (addr & S1_MASK == S1_BASE) go to slave port 1,
//   everything else to slave port 0. One transaction is outstanding at a time;
//   its response burst (ended by resp_last) is returned from the slave it was
//   sent to. Responses from the other slave are left blocked.
//   Optional build macro MEM_NOC_DEC_REQ_SLICE_EN inserts a one-entry register
//   slice between the master request port and the decoder.
//   Ports:
//     clk, rstn                          : clock, asynchronous active-low reset
//     m_req_valid/m_req_ready/m_req      : master request channel
//     m_resp_valid/m_resp_ready/m_resp   : master response channel
//     m_tid                              : decoded target of current m_req
//     s0_req_*, s0_resp_*                : slave-0 (memory) request/response
//     s1_req_*, s1_resp_*                : slave-1 (peripheral) request/response
// ---------------------------------------------------------------------------
module mem_noc_dec_1to2
    import mem_noc_dec_1to2_pkg::*;
#(
    parameter logic [MEM_ADDR_W-1:0] S1_BASE = 32'h1000_0000,
    parameter logic [MEM_ADDR_W-1:0] S1_MASK = 32'hF000_0000
) (
    input  logic      clk,
    input  logic      rstn,

    input  logic      m_req_valid,
    output logic      m_req_ready,
    input  mem_req_t  m_req,
    output logic      m_resp_valid,
    input  logic      m_resp_ready,
    output mem_resp_t m_resp,
    output logic      m_tid,

    output logic      s0_req_valid,
    input  logic      s0_req_ready,
    output mem_req_t  s0_req,
    input  logic      s0_resp_valid,
    output logic      s0_resp_ready,
    input  mem_resp_t s0_resp,

    output logic      s1_req_valid,
    input  logic      s1_req_ready,
    output mem_req_t  s1_req,
    input  logic      s1_resp_valid,
    output logic      s1_resp_ready,
    input  mem_resp_t s1_resp
);

    logic       hit1;

    // Request as seen by the decoder (master port directly, or slice output).
    logic       dec_valid;
    logic       dec_ready;
    mem_req_t   dec_req;
    logic       dec_tid;

    dec_state_e state;
    dec_state_e state_nxt;
    logic       tgt;
    logic       tgt_nxt;

    logic       is_resp;
    logic       sel_resp_valid;
    mem_resp_t  sel_resp;
    logic       last_hs;
    logic       can_issue;
    logic       req_hs;

    assign hit1  = noc_addr_hit(m_req.req_addr, S1_BASE, S1_MASK);
    assign m_tid = hit1;

`ifdef MEM_NOC_DEC_REQ_SLICE_EN
    mem_noc_req_slice u_req_slice (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (m_req_valid),
        .in_ready  (m_req_ready),
        .in_req    (m_req),
        .in_tid    (hit1),
        .out_valid (dec_valid),
        .out_ready (dec_ready),
        .out_req   (dec_req),
        .out_tid   (dec_tid)
    );
`else
    assign dec_valid   = m_req_valid;
    assign dec_req     = m_req;
    assign dec_tid     = hit1;
    assign m_req_ready = dec_ready;
`endif

    // Stage boundary: transaction state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= DEC_REQ;
            tgt   <= NOC_TID_S0;
        end else begin
            state <= state_nxt;
            tgt   <= tgt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        tgt_nxt        = tgt;
        is_resp        = (state == DEC_RESP);
        sel_resp_valid = 1'b0;
        sel_resp       = '0;
        m_resp_valid   = 1'b0;
        m_resp         = '0;
        s0_resp_ready  = 1'b0;
        s1_resp_ready  = 1'b0;
        last_hs        = 1'b0;
        can_issue      = 1'b0;
        dec_ready      = 1'b0;
        req_hs         = 1'b0;
        s0_req_valid   = 1'b0;
        s1_req_valid   = 1'b0;
        s0_req         = dec_req;
        s1_req         = dec_req;

        // Only the slave that owns the outstanding transaction is visible.
        if (is_resp) begin
            sel_resp_valid = (tgt == NOC_TID_S1) ? s1_resp_valid : s0_resp_valid;
            sel_resp       = (tgt == NOC_TID_S1) ? s1_resp : s0_resp;
            m_resp_valid   = sel_resp_valid;
            m_resp         = sel_resp;
            s0_resp_ready  = (tgt == NOC_TID_S0) & m_resp_ready;
            s1_resp_ready  = (tgt == NOC_TID_S1) & m_resp_ready;
        end

        last_hs = m_resp_valid & m_resp_ready & m_resp.resp_last;

        // The final beat frees the slot in its own cycle, so a waiting request
        // can issue back-to-back without a bubble.
        can_issue = ~is_resp | last_hs;

        s0_req_valid = dec_valid & ~dec_tid & can_issue;
        s1_req_valid = dec_valid &  dec_tid & can_issue;
        dec_ready    = can_issue & (dec_tid ? s1_req_ready : s0_req_ready);
        req_hs       = dec_valid & dec_ready;

        // A new request wins over the last-beat return to idle.
        if (req_hs) begin
            state_nxt = DEC_RESP;
            tgt_nxt   = dec_tid;
        end else if (last_hs) begin
            state_nxt = DEC_REQ;
        end
    end

endmodule

// File: tb/tb_mem_noc_dec_1to2.sv
module tb_mem_noc_dec_1to2;
    import mem_noc_dec_1to2_pkg::*;

    logic      clk;
    logic      rstn;
    logic      m_req_valid;
    logic      m_req_ready;
    mem_req_t  m_req;
    logic      m_resp_valid;
    logic      m_resp_ready;
    mem_resp_t m_resp;
    logic      m_tid;
    logic      s0_req_valid;
    logic      s0_req_ready;
    mem_req_t  s0_req;
    logic      s0_resp_valid;
    logic      s0_resp_ready;
    mem_resp_t s0_resp;
    logic      s1_req_valid;
    logic      s1_req_ready;
    mem_req_t  s1_req;
    logic      s1_resp_valid;
    logic      s1_resp_ready;
    mem_resp_t s1_resp;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: is a transaction outstanding, and which slave owns it.
    bit busy  = 1'b0;
    bit owner = 1'b0;
    bit last_req_hs = 1'b0;

    mem_noc_dec_1to2 dut (
        .clk           (clk),
        .rstn          (rstn),
        .m_req_valid   (m_req_valid),
        .m_req_ready   (m_req_ready),
        .m_req         (m_req),
        .m_resp_valid  (m_resp_valid),
        .m_resp_ready  (m_resp_ready),
        .m_resp        (m_resp),
        .m_tid         (m_tid),
        .s0_req_valid  (s0_req_valid),
        .s0_req_ready  (s0_req_ready),
        .s0_req        (s0_req),
        .s0_resp_valid (s0_resp_valid),
        .s0_resp_ready (s0_resp_ready),
        .s0_resp       (s0_resp),
        .s1_req_valid  (s1_req_valid),
        .s1_req_ready  (s1_req_ready),
        .s1_req        (s1_req),
        .s1_resp_valid (s1_resp_valid),
        .s1_resp_ready (s1_resp_ready),
        .s1_resp       (s1_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic mem_req_t mk_req(input logic [31:0] a);
        mem_req_t r;
        r.req_addr  = a;
        r.req_we    = 1'($urandom_range(0, 1));
        r.req_be    = 4'($urandom_range(0, 15));
        r.req_wdata = $urandom;
        return r;
    endfunction

    function automatic mem_resp_t mk_resp(input logic last);
        mem_resp_t r;
        r.resp_rdata = $urandom;
        r.resp_err   = 1'($urandom_range(0, 1));
        r.resp_last  = last;
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        case ($urandom_range(0, 2))
            0: a[31:28] = 4'h1;
            1: a[31:28] = 4'h0;
            default: ;
        endcase
        return a;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks every output against the model in the current cycle, then
    // advances one clock and updates the model from the handshakes that
    // the rules say happened.
    task automatic step(input string tag);
        logic      hit;
        logic      ev;
        mem_resp_t er;
        logic      ldone;
        logic      free;
        logic      exp_rdy;
        logic      req_hs;
        #4;
        hit     = (m_req.req_addr & 32'hF000_0000) == 32'h1000_0000;
        ev      = busy && (owner ? s1_resp_valid : s0_resp_valid);
        er      = busy ? (owner ? s1_resp : s0_resp) : '0;
        ldone   = ev && m_resp_ready && er.resp_last;
        free    = !busy || ldone;
        exp_rdy = free && (hit ? s1_req_ready : s0_req_ready);

        chk({tag, ".m_tid"},         128'(m_tid),         128'(hit));
        chk({tag, ".m_req_ready"},   128'(m_req_ready),   128'(exp_rdy));
        chk({tag, ".s0_req_valid"},  128'(s0_req_valid),  128'(m_req_valid && !hit && free));
        chk({tag, ".s1_req_valid"},  128'(s1_req_valid),  128'(m_req_valid && hit && free));
        chk({tag, ".s0_req"},        128'(s0_req),        128'(m_req));
        chk({tag, ".s1_req"},        128'(s1_req),        128'(m_req));
        chk({tag, ".m_resp_valid"},  128'(m_resp_valid),  128'(ev));
        chk({tag, ".m_resp"},        128'(m_resp),        128'(er));
        chk({tag, ".s0_resp_ready"}, 128'(s0_resp_ready), 128'(busy && !owner && m_resp_ready));
        chk({tag, ".s1_resp_ready"}, 128'(s1_resp_ready), 128'(busy && owner && m_resp_ready));

        req_hs = m_req_valid && exp_rdy;
        @(posedge clk);
        if (rstn) begin
            if (req_hs) begin
                busy  = 1'b1;
                owner = hit;
            end else if (ldone) begin
                busy = 1'b0;
            end
        end
        last_req_hs = req_hs && rstn;
        #1;
    endtask

    initial begin
        rstn          = 1'b0;
        m_req_valid   = 1'b0;
        m_req         = mk_req(32'h0);
        m_resp_ready  = 1'b1;
        s0_req_ready  = 1'b1;
        s1_req_ready  = 1'b1;
        s0_resp_valid = 1'b0;
        s1_resp_valid = 1'b0;
        s0_resp       = mk_resp(1'b0);
        s1_resp       = mk_resp(1'b0);
        @(posedge clk);
        #1;

        // Reset state, including a response offered while in reset.
        step("rst0");
        s1_resp_valid = 1'b1;
        step("rst1");
        s1_resp_valid = 1'b0;
        rstn = 1'b1;

        // Slave-0 request and 4-beat burst.
        m_req_valid = 1'b1;
        m_req       = mk_req(32'h0000_0100);
        step("t1_req");
        m_req_valid = 1'b0;
        for (int b = 1; b <= 4; b++) begin
            s0_resp_valid = 1'b1;
            s0_resp       = mk_resp(b == 4);
            step("t1_beat");
        end
        s0_resp_valid = 1'b0;
        step("t1_idle");

        // Slave-1 request; stray s0 response; second request waits for last beat.
        m_req_valid = 1'b1;
        m_req       = mk_req(32'h1000_0040);
        step("t2_req");
        m_req         = mk_req(32'h0000_0200);
        s0_resp_valid = 1'b1;
        s0_resp       = mk_resp(1'b1);
        s1_resp_valid = 1'b1;
        s1_resp       = mk_resp(1'b0);
        step("t2_beat1_blocked");
        s1_resp = mk_resp(1'b1);
        step("t3_last_b2b");
        m_req_valid   = 1'b0;
        s1_resp_valid = 1'b0;

        // Master response backpressure on the slave-0 transaction.
        m_resp_ready = 1'b0;
        step("t4_hold0");
        step("t4_hold1");
        m_resp_ready = 1'b1;
        step("t4_release");
        s0_resp_valid = 1'b0;

        // Slave request backpressure for 3 cycles.
        s0_req_ready = 1'b0;
        m_req_valid  = 1'b1;
        m_req        = mk_req(32'h0000_0300);
        repeat (3) step("t4_req_bp");
        s0_req_ready = 1'b1;
        step("t4_req_acc");
        m_req_valid   = 1'b0;
        s0_resp_valid = 1'b1;
        s0_resp       = mk_resp(1'b1);
        step("t4_resp");
        s0_resp_valid = 1'b0;

        // Reset in the middle of a burst, then a fresh slave-1 request.
        m_req_valid = 1'b1;
        m_req       = mk_req(32'h0000_0400);
        step("t6_req");
        m_req_valid   = 1'b0;
        s0_resp_valid = 1'b1;
        s0_resp       = mk_resp(1'b0);
        step("t6_beat1");
        s0_resp = mk_resp(1'b0);
        #2;
        rstn = 1'b0;
        busy = 1'b0;
        step("t6_rst");
        step("t6_rst_hold");
        s0_resp_valid = 1'b0;
        rstn          = 1'b1;
        m_req_valid   = 1'b1;
        m_req         = mk_req(32'h1000_0080);
        step("t6_s1_req");
        m_req_valid   = 1'b0;
        s1_resp_valid = 1'b1;
        s1_resp       = mk_resp(1'b1);
        step("t6_s1_resp");
        s1_resp_valid = 1'b0;
        step("t6_idle");

        // Randomized traffic; a request is held stable until accepted.
        for (int i = 0; i < 600; i++) begin
            if (!(m_req_valid && !last_req_hs)) begin
                m_req_valid = ($urandom_range(0, 2) != 0);
                m_req       = mk_req(rand_addr());
            end
            s0_req_ready  = ($urandom_range(0, 3) != 0);
            s1_req_ready  = ($urandom_range(0, 3) != 0);
            s0_resp_valid = 1'($urandom_range(0, 1));
            s1_resp_valid = 1'($urandom_range(0, 1));
            s0_resp       = mk_resp($urandom_range(0, 2) == 0);
            s1_resp       = mk_resp($urandom_range(0, 2) == 0);
            m_resp_ready  = ($urandom_range(0, 3) != 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_noc_dec_1to2.md
Name: mem_noc_dec_1to2

Overview:
- 1-master-to-2-slave address decoder/router for the memory NoC. It sits directly upstream of the 2:1 memory-NoC arbiters.
- Each core master (IFU, LSU) gets one instance. Slave port 0 drives the arbiter in front of memory; slave port 1 drives the arbiter in front of the peripheral/alternate target.
- The block decodes the request address and forwards the request to one slave port. It tracks the single outstanding transaction and returns that slave's response beats (burst, terminated by resp_last) to the master.
- It also drives the decoded target id that the downstream arbiter compares against its slave tid.

Parameters:
- S1_BASE, 32'h1000_0000, slave-1 region base; a request hits slave 1 when (req_addr & S1_MASK) == S1_BASE.
- S1_MASK, 32'hF000_0000, slave-1 region compare mask; any non-hit goes to slave 0 (default slave).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- m_req_valid  in  1  master request valid
- m_req_ready  out  1  master request ready
- m_req  in  mem_req_t  master request
- m_resp_valid  out  1  response valid to master
- m_resp_ready  in  1  master response ready
- m_resp  out  mem_resp_t  response to master
- m_tid  out  1  decoded target of current m_req (0 = slave 0, 1 = slave 1)
- s0_req_valid / s0_req_ready / s0_req  out/in/out  1/1/mem_req_t  slave-0 request channel
- s0_resp_valid / s0_resp_ready / s0_resp  in/out/in  1/1/mem_resp_t  slave-0 response channel
- s1_req_valid / s1_req_ready / s1_req  out/in/out  1/1/mem_req_t  slave-1 request channel
- s1_resp_valid / s1_resp_ready / s1_resp  in/out/in  1/1/mem_resp_t  slave-1 response channel

Behaviour:
- Decode:
  - hit1 = (m_req.req_addr & S1_MASK) == S1_BASE, computed over MEM_ADDR_W bits.
  - m_tid = hit1, combinational, valid whenever m_req_valid.
- State:
  - 1-bit FSM {DEC_REQ, DEC_RESP}.
  - 1-bit register tgt holds the target of the outstanding transaction.
  - Reset: DEC_REQ, tgt = 0.
- Request path:
  - sX_req = m_req, always.
  - s1_req_valid = m_req_valid & hit1 & can_issue.
  - s0_req_valid = m_req_valid & ~hit1 & can_issue.
  - m_req_ready = can_issue & (hit1 ? s1_req_ready : s0_req_ready).
- can_issue:
  - 1 in DEC_REQ.
  - In DEC_RESP: 1 only in the cycle the final beat (resp_last) handshakes on the master side.
  - This allows back-to-back transactions with zero bubble. At most one transaction is outstanding per instance.
- Request handshake (m_req_valid & m_req_ready):
  - tgt <= hit1; next state = DEC_RESP.
  - The handshake takes priority over the last-beat return to DEC_REQ in the same cycle.
- Response path:
  - m_resp_valid = is_resp & (tgt ? s1_resp_valid : s0_resp_valid).
  - m_resp = the selected slave response; all-zero when not in DEC_RESP.
  - s(tgt)_resp_ready = is_resp & m_resp_ready. The non-selected slave sees resp_ready = 0.
- Last beat:
  - m_resp_valid & m_resp_ready & m_resp.resp_last, with no new request handshake, -> DEC_REQ.
  - Non-last beats keep DEC_RESP.
- Stray responses: responses from the non-selected slave, or any response while in DEC_REQ, are not acknowledged; they stay blocked.
- Protocol: m_req_valid must hold until ready (AXI-style). The block never drops a valid request.
- Reset values (during rstn low):
  - m_resp_valid = 0, m_resp = 0, s0/s1_resp_ready = 0.
  - Request outputs as in DEC_REQ, combinational pass-through.
- Reset mid-burst: state returns to DEC_REQ immediately and the outstanding transaction is abandoned. Downstream blocks share rstn.
- Latency: request path 0 cycles (combinational); response path 0 cycles.

Optional Feature:
- Macro: MEM_NOC_DEC_REQ_SLICE_EN.
- Defined: a one-entry request register slice sits between the master request port and the decoder.
  - m_req_ready = ~slice_full | slice_pop.
  - The decoded request and tid are registered, adding 1 cycle of request latency at full throughput.
  - The slice empties on reset.
  - can_issue and the FSM act on the slice output.
- Undefined: pure combinational request path as above.

Decomposition:
- urv_typedef: mem_req_t, mem_resp_t (existing).
- urv_cfg: MEM_ADDR_W, plus new constants NOC_TID_S0 = 1'b0, NOC_TID_S1 = 1'b1.
- Sub-module mem_noc_req_slice: a generic valid/ready one-entry register on mem_req_t + tid, used only under MEM_NOC_DEC_REQ_SLICE_EN. Flops use stdffrv/stdffre.

Test Plan:
- Request addr 32'h0000_0100, both slaves ready -> s0_req_valid = 1, m_tid = 0, s1_req_valid = 0. A 4-beat s0 burst (last on beat 4) reaches the master unchanged; FSM returns to DEC_REQ after beat 4.
- Request addr 32'h1000_0040 -> s1_req_valid = 1, m_tid = 1. s0 asserts resp_valid concurrently -> s0_resp_ready stays 0, m_resp_valid follows s1 only.
- Back-to-back: second request (addr 32'h0000_0200) held valid during the final s1 beat -> accepted in the same cycle as the s1 last beat handshake; tgt = 0; no idle cycle.
- Backpressure: s0_req_ready = 0 for 3 cycles -> m_req_ready = 0 for those cycles, s0_req stable. m_resp_ready = 0 mid-burst -> s0_resp_ready = 0 and the beat is held.
- Second request while a response is outstanding (non-last beat) -> m_req_ready = 0 until the last beat.
- Assert rstn low mid-burst (beat 2 of 4) -> m_resp_valid = 0 immediately; after release, FSM is in DEC_REQ and a new request to slave 1 is accepted normally. With MEM_NOC_DEC_REQ_SLICE_EN, s1_req_valid appears 1 cycle after m_req handshake.
